// File: rtl/alu_bus_sequencer_if.sv
// Command and datapath-strobe bundle between the instruction decoder and the ALU bus sequencer.
// The master side issues commands; the slave side is the sequencer that drives the strobes.
interface alu_bus_sequencer_if #(
  parameter int NREG = 8
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  logic            start;
  logic [2:0]      op;
  logic [IW-1:0]   src_a;
  logic [IW-1:0]   src_b;
  logic [IW-1:0]   dst;

  logic            ready;
  logic            busy;
  logic            done;
  logic            err;
  logic [NREG-1:0] reg_out_en;
  logic [NREG-1:0] reg_in_en;
  logic            Y_in;
  logic [2:0]      alu_op;
  logic            Z_in;
  logic            Z_out;

  modport master (
    output start, op, src_a, src_b, dst,
    input  ready, busy, done, err, reg_out_en, reg_in_en, Y_in, alu_op, Z_in, Z_out
  );

  modport slave (
    input  start, op, src_a, src_b, dst,
    output ready, busy, done, err, reg_out_en, reg_in_en, Y_in, alu_op, Z_in, Z_out
  );
endinterface

// File: rtl/alu_bus_sequencer.sv
// Micro-step controller for one register-to-register ALU operation over the shared tri-state bus.
// Every output is decoded from the registered state and the latched command, never from inputs.
module alu_bus_sequencer #(
  parameter int         NREG     = 8,
  parameter logic [2:0] UNARY_OP = 3'b111
) (
  input  logic               clk,
  input  logic               reset,
  alu_bus_sequencer_if.slave bus
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_SHIFT_Z,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [2:0]      op_q;
  logic [IW-1:0]   src_a_q;
  logic [IW-1:0]   src_b_q;
  logic [IW-1:0]   dst_q;
  logic            err_q;

  logic            accept;
  logic            cmd_valid;

  logic            ready;
  logic            busy;
  logic            done;
  logic [NREG-1:0] reg_out_en;
  logic [NREG-1:0] reg_in_en;
  logic            y_in;
  logic [2:0]      alu_op;
  logic            z_in;
  logic            z_out;

  // Out-of-range indices are only reachable when NREG is not a power of two.
  function automatic logic idx_ok(input logic [IW-1:0] idx);
    return 32'(idx) < 32'(NREG);
  endfunction

  function automatic logic [NREG-1:0] onehot(input logic [IW-1:0] idx);
    return NREG'(1) << idx;
  endfunction

  assign cmd_valid = idx_ok(bus.src_a) && idx_ok(bus.src_b) && idx_ok(bus.dst);
  assign accept    = (state == S_IDLE) && bus.start;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.start && cmd_valid)
          state_nxt = (bus.op == UNARY_OP) ? S_EXEC : S_LOAD_Y;
      end
      S_LOAD_Y:  state_nxt = S_EXEC;
      S_EXEC:    state_nxt = S_SHIFT_Z;
      S_SHIFT_Z: state_nxt = S_WRITE;
      S_WRITE:   state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Command capture; later input changes cannot disturb an operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !cmd_valid;
      if (accept) begin
        op_q    <= bus.op;
        src_a_q <= bus.src_a;
        src_b_q <= bus.src_b;
        dst_q   <= bus.dst;
      end
    end
  end

  // Output decode; at most one bus driver is enabled in any state
  always_comb begin
    ready      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    reg_out_en = '0;
    reg_in_en  = '0;
    y_in       = 1'b0;
    alu_op     = 3'd0;
    z_in       = 1'b0;
    z_out      = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      S_LOAD_Y: begin
        reg_out_en = onehot(src_a_q);
        y_in       = 1'b1;
      end
      S_EXEC: begin
        reg_out_en = (op_q == UNARY_OP) ? onehot(src_a_q) : onehot(src_b_q);
        alu_op     = op_q;
        z_in       = 1'b1;
      end
      // Second Z_in moves Z1 into Z2 so the bus can see the result next cycle.
      S_SHIFT_Z: z_in = 1'b1;
      S_WRITE: begin
        z_out     = 1'b1;
        reg_in_en = onehot(dst_q);
      end
      S_DONE:  done = 1'b1;
      default: begin
        ready = 1'b0;
        busy  = 1'b1;
      end
    endcase
  end

  assign bus.ready      = ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err_q;
  assign bus.reg_out_en = reg_out_en;
  assign bus.reg_in_en  = reg_in_en;
  assign bus.Y_in       = y_in;
  assign bus.alu_op     = alu_op;
  assign bus.Z_in       = z_in;
  assign bus.Z_out      = z_out;

  a_bus_exclusive: assert property (@(posedge clk) disable iff (reset)
    $countones({reg_out_en, z_out}) <= 1);
  a_write_only_in_write: assert property (@(posedge clk) disable iff (reset)
    (reg_in_en != '0) |-> (state == S_WRITE));
  a_in_en_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(reg_in_en));
endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Directed bench for alu_bus_sequencer: per-cycle strobe patterns for each command kind,
// back-to-back handshake, reset abort, index rejection (NREG=6) and a randomised invariant run.
module tb_alu_bus_sequencer;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  alu_bus_sequencer_if #(.NREG(8)) bus8 ();
  alu_bus_sequencer_if #(.NREG(6)) bus6 ();

  alu_bus_sequencer #(.NREG(8), .UNARY_OP(3'b111)) u8 (.clk(clk), .reset(reset), .bus(bus8));
  alu_bus_sequencer #(.NREG(6), .UNARY_OP(3'b111)) u6 (.clk(clk), .reset(reset), .bus(bus6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] obs8();
    return {bus8.ready, bus8.busy, bus8.done, bus8.err, bus8.reg_out_en, bus8.reg_in_en,
            bus8.Y_in, bus8.alu_op, bus8.Z_in, bus8.Z_out};
  endfunction

  function automatic logic [25:0] exp8(input logic rdy, input logic bsy, input logic dn,
                                       input logic er, input logic [7:0] roe,
                                       input logic [7:0] rie, input logic y,
                                       input logic [2:0] aop, input logic zi, input logic zo);
    return {rdy, bsy, dn, er, roe, rie, y, aop, zi, zo};
  endfunction

  function automatic logic [21:0] obs6();
    return {bus6.ready, bus6.busy, bus6.done, bus6.err, bus6.reg_out_en, bus6.reg_in_en,
            bus6.Y_in, bus6.alu_op, bus6.Z_in, bus6.Z_out};
  endfunction

  function automatic logic [21:0] exp6(input logic rdy, input logic bsy, input logic dn,
                                       input logic er, input logic [5:0] roe,
                                       input logic [5:0] rie, input logic y,
                                       input logic [2:0] aop, input logic zi, input logic zo);
    return {rdy, bsy, dn, er, roe, rie, y, aop, zi, zo};
  endfunction

  task automatic cmd8(input logic s, input logic [2:0] o, input logic [2:0] a,
                      input logic [2:0] b, input logic [2:0] d);
    bus8.start = s; bus8.op = o; bus8.src_a = a; bus8.src_b = b; bus8.dst = d;
  endtask

  task automatic cmd6(input logic s, input logic [2:0] o, input logic [2:0] a,
                      input logic [2:0] b, input logic [2:0] d);
    bus6.start = s; bus6.op = o; bus6.src_a = a; bus6.src_b = b; bus6.dst = d;
  endtask

  task automatic test_reset();
    logic [25:0] idle8;
    logic [21:0] idle6;
    idle8 = exp8(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    idle6 = exp6(1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    reset = 1'b1;
    cmd8(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    cmd6(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    tick(); tick();
    checks++;
    if (obs8() !== idle8) begin
      errors++; $display("FAIL reset8: got %h want %h", obs8(), idle8);
    end
    checks++;
    if (obs6() !== idle6) begin
      errors++; $display("FAIL reset6: got %h want %h", obs6(), idle6);
    end
    // A start held during reset must not be accepted.
    cmd8(1'b1, 3'd0, 3'd1, 3'd2, 3'd3);
    tick();
    checks++;
    if (obs8() !== idle8) begin
      errors++; $display("FAIL reset_start_ignored: got %h want %h", obs8(), idle8);
    end
    cmd8(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    reset = 1'b0;
    tick();
    checks++;
    if (obs8() !== idle8) begin
      errors++; $display("FAIL reset_release: got %h want %h", obs8(), idle8);
    end
  endtask

  task automatic test_binary();
    logic [25:0] e[6];
    e[0] = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
    e[1] = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    e[2] = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    e[3] = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 3'd0, 1'b0, 1'b1);
    e[4] = exp8(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    e[5] = exp8(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    cmd8(1'b1, 3'b000, 3'd2, 3'd5, 3'd7);
    tick();
    cmd8(1'b0, 3'b011, 3'd6, 3'd1, 3'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs8() !== e[i]) begin
        errors++; $display("FAIL binary_step%0d: got %h want %h", i, obs8(), e[i]);
      end
    end
  endtask

  task automatic test_binary_op5();
    logic [25:0] e[6];
    e[0] = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
    e[1] = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 3'd5, 1'b1, 1'b0);
    e[2] = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    e[3] = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 3'd0, 1'b0, 1'b1);
    e[4] = exp8(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    e[5] = exp8(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    cmd8(1'b1, 3'b101, 3'd0, 3'd1, 3'd2);
    tick();
    cmd8(1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs8() !== e[i]) begin
        errors++; $display("FAIL op5_step%0d: got %h want %h", i, obs8(), e[i]);
      end
    end
  endtask

  task automatic test_unary();
    logic [25:0] e[5];
    e[0] = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 3'd7, 1'b1, 1'b0);
    e[1] = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    e[2] = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 3'd0, 1'b0, 1'b1);
    e[3] = exp8(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    e[4] = exp8(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    cmd8(1'b1, 3'b111, 3'd3, 3'd6, 3'd3);
    tick();
    cmd8(1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs8() !== e[i]) begin
        errors++; $display("FAIL unary_step%0d: got %h want %h", i, obs8(), e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] e[11];
    e[0]  = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
    e[1]  = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    e[2]  = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    e[3]  = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 3'd0, 1'b0, 1'b1);
    e[4]  = exp8(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    e[5]  = exp8(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    e[6]  = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 3'd7, 1'b1, 1'b0);
    e[7]  = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    e[8]  = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 3'd0, 1'b0, 1'b1);
    e[9]  = exp8(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    e[10] = exp8(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    cmd8(1'b1, 3'b000, 3'd1, 3'd4, 3'd6);
    tick();
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs8() !== e[i]) begin
        errors++; $display("FAIL b2b_step%0d: got %h want %h", i, obs8(), e[i]);
      end
      if (i == 0) cmd8(1'b1, 3'b011, 3'd0, 3'd0, 3'd0);
      if (i == 1) cmd8(1'b1, 3'b111, 3'd5, 3'd2, 3'd1);
      if (i == 6) cmd8(1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
    end
  endtask

  task automatic test_reset_abort();
    logic [25:0] exec8;
    logic [25:0] idle8;
    exec8 = exp8(1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    idle8 = exp8(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    cmd8(1'b1, 3'b000, 3'd2, 3'd5, 3'd7);
    tick();
    cmd8(1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
    tick();
    checks++;
    if (obs8() !== exec8) begin
      errors++; $display("FAIL abort_exec: got %h want %h", obs8(), exec8);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs8() !== idle8) begin
      errors++; $display("FAIL abort_reset: got %h want %h", obs8(), idle8);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs8() !== idle8) begin
        errors++; $display("FAIL abort_after%0d: got %h want %h", i, obs8(), idle8);
      end
    end
  endtask

  task automatic test_nreg6();
    logic [21:0] idle6;
    logic [21:0] err6;
    logic [21:0] e[6];
    idle6 = exp6(1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    err6  = exp6(1'b1, 1'b0, 1'b0, 1'b1, 6'h00, 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    e[0] = exp6(1'b0, 1'b1, 1'b0, 1'b0, 6'h20, 6'h00, 1'b1, 3'd0, 1'b0, 1'b0);
    e[1] = exp6(1'b0, 1'b1, 1'b0, 1'b0, 6'h01, 6'h00, 1'b0, 3'd2, 1'b1, 1'b0);
    e[2] = exp6(1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    e[3] = exp6(1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 6'h10, 1'b0, 3'd0, 1'b0, 1'b1);
    e[4] = exp6(1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    e[5] = idle6;
    cmd6(1'b1, 3'b000, 3'd1, 3'd2, 3'd6);
    tick();
    cmd6(1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
    checks++;
    if (obs6() !== err6) begin
      errors++; $display("FAIL nreg6_dst_err: got %h want %h", obs6(), err6);
    end
    tick();
    checks++;
    if (obs6() !== idle6) begin
      errors++; $display("FAIL nreg6_err_pulse: got %h want %h", obs6(), idle6);
    end
    cmd6(1'b1, 3'b111, 3'd7, 3'd0, 3'd0);
    tick();
    cmd6(1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
    checks++;
    if (obs6() !== err6) begin
      errors++; $display("FAIL nreg6_src_err: got %h want %h", obs6(), err6);
    end
    tick();
    checks++;
    if (obs6() !== idle6) begin
      errors++; $display("FAIL nreg6_src_err_end: got %h want %h", obs6(), idle6);
    end
    cmd6(1'b1, 3'b010, 3'd5, 3'd0, 3'd4);
    tick();
    cmd6(1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs6() !== e[i]) begin
        errors++; $display("FAIL nreg6_step%0d: got %h want %h", i, obs6(), e[i]);
      end
    end
  endtask

  task automatic test_random();
    int   accepts;
    int   dones;
    int   zin_cnt;
    logic inflight;
    accepts  = 0;
    dones    = 0;
    zin_cnt  = 0;
    inflight = 1'b0;
    for (int cyc = 0; cyc < 1006; cyc++) begin
      if (cyc < 1000)
        cmd8(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 6)),
             3'($urandom), 3'($urandom), 3'($urandom));
      else
        cmd8(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
      if (bus8.ready && bus8.start) begin
        checks++;
        if (inflight !== 1'b0) begin
          errors++; $display("FAIL rand_accept_while_inflight: got %b want 0", inflight);
        end
        inflight = 1'b1;
        zin_cnt  = 0;
        accepts++;
      end
      tick();
      checks++;
      if (($countones(bus8.reg_out_en) + int'(bus8.Z_out)) > 1) begin
        errors++; $display("FAIL rand_exclusive: got roe=%h zout=%b want at most one driver",
                           bus8.reg_out_en, bus8.Z_out);
      end
      checks++;
      if ((bus8.reg_in_en != 8'h00) && (bus8.Z_out !== 1'b1)) begin
        errors++; $display("FAIL rand_write_window: got rie=%h zout=%b want zout=1",
                           bus8.reg_in_en, bus8.Z_out);
      end
      checks++;
      if (bus8.ready !== ~bus8.busy) begin
        errors++; $display("FAIL rand_ready_busy: got ready=%b busy=%b want complementary",
                           bus8.ready, bus8.busy);
      end
      if (bus8.Z_in) zin_cnt++;
      if (bus8.done) begin
        dones++;
        checks++;
        if (!inflight || zin_cnt != 2) begin
          errors++; $display("FAIL rand_done: got inflight=%b zin=%0d want inflight=1 zin=2",
                             inflight, zin_cnt);
        end
        inflight = 1'b0;
      end
    end
    checks++;
    if (dones != accepts || accepts < 50) begin
      errors++; $display("FAIL rand_counts: got dones=%0d accepts=%0d want equal and >=50",
                         dones, accepts);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    test_reset();
    test_binary();
    test_binary_op5();
    test_unary();
    test_back_to_back();
    test_reset_abort();
    test_nreg6();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
